gpio_port: RTL and testbench

Parametrised GPIO peripheral that replaces the fixed 13-in/8-out pin wiring of the board top with a bus-addressable block. It synchronises and debounces N_IN input pins, drives N_OUT output pins from a register with atomic set/clear, and detects per-pin rising and falling edges into a write-1-to-clear status register with a level interrupt. It sits between the core's data-memory bus decode and the board pins.

---
 rtl/gpio_port.sv | 135 +++++++++++++
 tb/tb_gpio_port.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_port.sv
`default_nettype none
// ============================================================================
// Module   : gpio_port
// Summary  : Bus-addressable GPIO block. Inputs are synchronised, debounced and
//            edge-detected into a W1C status register with a level irq. Outputs
//            come from a register that supports atomic set and clear.
// Revision : 1.0
// ============================================================================
module gpio_port #(
    parameter int               N_IN            = 13,
    parameter int               N_OUT           = 8,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter logic [N_OUT-1:0] OUT_INIT        = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       addr,
    input  logic             we,
    input  logic             re,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic [N_IN-1:0]  gpio_pin_in,
    output logic [N_OUT-1:0] gpio_pin_out,
    output logic             irq
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_A_DIN     = 3'd0;
    localparam logic [2:0] c_A_DOUT    = 3'd1;
    localparam logic [2:0] c_A_SET     = 3'd2;
    localparam logic [2:0] c_A_CLR     = 3'd3;
    localparam logic [2:0] c_A_RISE_EN = 3'd4;
    localparam logic [2:0] c_A_FALL_EN = 3'd5;
    localparam logic [2:0] c_A_STATUS  = 3'd6;

    logic [2:0]       w_idx;
    logic [N_IN-1:0]  w_stable;
    logic [N_IN-1:0]  r_stable_d;
    logic [N_IN-1:0]  r_rise_en;
    logic [N_IN-1:0]  r_fall_en;
    logic [N_IN-1:0]  r_status;
    logic [N_IN-1:0]  w_evt;
    logic [N_IN-1:0]  w_clr;
    logic [N_OUT-1:0] r_dout;
    logic [N_OUT-1:0] w_dout_nxt;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_idx    = addr[4:2];
    assign w_unused = &{1'b0, addr[1:0], wdata};

    // Per-pin synchroniser and debouncer; the stable bit only moves after the
    // synchronised value has disagreed with it for DEBOUNCE_CYCLES edges.
    for (genvar i = 0; i < N_IN; i++) begin : g_in
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_stable;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync   <= '0;
                r_cnt    <= '0;
                r_stable <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_pin_in[i]};
                if (r_sync[SYNC_STAGES-1] == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_stable <= r_sync[SYNC_STAGES-1];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end

        assign w_stable[i] = r_stable;
    end

    assign w_evt = (w_stable & ~r_stable_d & r_rise_en) |
                   (~w_stable & r_stable_d & r_fall_en);
    assign w_clr = (we && (w_idx == c_A_STATUS)) ? wdata[N_IN-1:0] : '0;

    always_comb begin
        w_dout_nxt = r_dout;
        if (we) begin
            case (w_idx)
                c_A_DOUT: w_dout_nxt = wdata[N_OUT-1:0];
                c_A_SET:  w_dout_nxt = r_dout | wdata[N_OUT-1:0];
                c_A_CLR:  w_dout_nxt = r_dout & ~wdata[N_OUT-1:0];
                default:  w_dout_nxt = r_dout;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_A_DIN:     w_rdata = 32'(w_stable);
            c_A_DOUT:    w_rdata = 32'(r_dout);
            c_A_RISE_EN: w_rdata = 32'(r_rise_en);
            c_A_FALL_EN: w_rdata = 32'(r_fall_en);
            c_A_STATUS:  w_rdata = 32'(r_status);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= OUT_INIT;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_status   <= '0;
            r_stable_d <= '0;
            rdata      <= '0;
            irq        <= 1'b0;
        end else begin
            r_dout     <= w_dout_nxt;
            r_stable_d <= w_stable;
            // A new event beats a simultaneous W1C of the same bit.
            r_status   <= (r_status & ~w_clr) | w_evt;
            irq        <= |r_status;
            if (we && (w_idx == c_A_RISE_EN)) r_rise_en <= wdata[N_IN-1:0];
            if (we && (w_idx == c_A_FALL_EN)) r_fall_en <= wdata[N_IN-1:0];
            if (re) rdata <= w_rdata;
        end
    end

    assign gpio_pin_out = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_gpio_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_port
// Summary  : Directed self-checking bench for gpio_port with OUT_INIT = 8'hA5.
// Revision : 1.0
// ============================================================================
module tb_gpio_port;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [12:0] gpio_pin_in;
    logic [7:0]  gpio_pin_out;
    logic        irq;

    int n_cmp;
    int n_err;

    gpio_port #(
        .N_IN            (13),
        .N_OUT           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .OUT_INIT        (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .we           (we),
        .re           (re),
        .wdata        (wdata),
        .rdata        (rdata),
        .gpio_pin_in  (gpio_pin_in),
        .gpio_pin_out (gpio_pin_out),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
        d    = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0; gpio_pin_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_pin_out", 32'(gpio_pin_out), 32'hA5);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd(5'h18, v); chk("rst_status", v, 32'h0);

        // Output register with set/clear
        wr(5'h04, 32'hF0); chk("dout_wr", 32'(gpio_pin_out), 32'hF0);
        wr(5'h08, 32'h0F); chk("dout_set", 32'(gpio_pin_out), 32'hFF);
        wr(5'h0C, 32'h81); chk("dout_clr", 32'(gpio_pin_out), 32'h7E);
        rd(5'h04, v); chk("dout_rd", v, 32'h7E);
        rd(5'h08, v); chk("set_wo_rd", v, 32'h0);
        rd(5'h1C, v); chk("unmapped_rd", v, 32'h0);
        wr(5'h00, 32'hFFFF_FFFF);
        rd(5'h00, v); chk("din_ro", v, 32'h0);
        wr(5'h10, 32'hFFFF_FFFF);
        rd(5'h10, v); chk("rise_en_width", v, 32'h1FFF);
        wr(5'h10, 32'h0);

        // Steady pin: DIN updates on the 18th edge, visible in rdata after the 19th
        gpio_pin_in[3] = 1'b1; addr = 5'h00; re = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("din_lat_%0d", k), rdata, (k >= 19) ? 32'h8 : 32'h0);
        end
        re = 1'b0;
        gpio_pin_in[3] = 1'b0;
        repeat (25) @(negedge clk);
        rd(5'h00, v); chk("din_back_0", v, 32'h0);

        // 15-cycle glitch is filtered
        gpio_pin_in[3] = 1'b1; addr = 5'h00; re = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 15) gpio_pin_in[3] = 1'b0;
            chk($sformatf("glitch_%0d", k), rdata, 32'h0);
        end
        re = 1'b0;

        // Rise event: STATUS on edge 19, irq on edge 20
        wr(5'h10, 32'h008);
        wr(5'h14, 32'h000);
        gpio_pin_in[3] = 1'b1; addr = 5'h18; re = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("rise_status_%0d", k), rdata, (k >= 20) ? 32'h8 : 32'h0);
            chk($sformatf("rise_irq_%0d", k), 32'(irq), (k >= 20) ? 32'h1 : 32'h0);
        end
        re = 1'b0;
        gpio_pin_in[3] = 1'b0;
        repeat (25) @(negedge clk);
        rd(5'h18, v); chk("fall_disabled", v, 32'h8);
        chk("fall_irq", 32'(irq), 32'h1);
        wr(5'h18, 32'h008);
        rd(5'h18, v); chk("w1c_status", v, 32'h0);
        chk("w1c_irq", 32'(irq), 32'h0);

        // Event and W1C on the same edge: set wins
        gpio_pin_in[3] = 1'b1;
        repeat (18) @(negedge clk);
        wr(5'h18, 32'h008);
        @(negedge clk);
        chk("collide_irq", 32'(irq), 32'h1);
        wr(5'h10, 32'h0);
        rd(5'h18, v); chk("collide_status", v, 32'h8);
        chk("collide_irq_hold", 32'(irq), 32'h1);
        wr(5'h18, 32'h008);

        // Reset in the middle of a debounce count
        gpio_pin_in[3] = 1'b0;
        repeat (25) @(negedge clk);
        wr(5'h10, 32'h008);
        gpio_pin_in[3] = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_pin_out", 32'(gpio_pin_out), 32'hA5);
        chk("arst_irq", 32'(irq), 32'h0);
        chk("arst_rdata", rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr(5'h10, 32'h008);
        addr = 5'h00; re = 1'b1;
        for (int k = 2; k <= 21; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_din_%0d", k), rdata, (k >= 19) ? 32'h8 : 32'h0);
            chk($sformatf("post_rst_irq_%0d", k), 32'(irq), (k >= 20) ? 32'h1 : 32'h0);
        end
        re = 1'b0;
        rd(5'h18, v); chk("post_rst_status", v, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
